// File: rtl/dcache_pkg.sv
// Shared types and constants for the direct-mapped write-through data cache.
// Optional statistics counters are enabled with the DCACHE_STATS_EN macro.
package dcache_pkg;

   localparam int WORD_W          = 16;
   localparam int DEF_INDEX_BITS  = 4;
   localparam int DEF_ADDR_BITS   = 16;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_MISS = 3'd1,
      WR_THRU = 3'd2,
      RD_DONE = 3'd3,
      WR_DONE = 3'd4
   } state_t;

   function automatic int tag_width(input int addr_bits, input int index_bits);
      return addr_bits - index_bits;
   endfunction

endpackage

// File: rtl/dcache_line_store.sv
// Tag/valid/data arrays for the data cache: one combinational read port,
// one synchronous write port, valid bits cleared by synchronous reset.
module dcache_line_store
   import dcache_pkg::*;
#(
   parameter int INDEX_BITS = DEF_INDEX_BITS,
   parameter int TAG_W      = DEF_ADDR_BITS - DEF_INDEX_BITS
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [INDEX_BITS-1:0] rd_index,
   output logic                  rd_valid,
   output logic [TAG_W-1:0]      rd_tag,
   output logic [WORD_W-1:0]     rd_data,
   input  logic                  wr_en,
   input  logic [INDEX_BITS-1:0] wr_index,
   input  logic [TAG_W-1:0]      wr_tag,
   input  logic [WORD_W-1:0]     wr_data
);

   localparam int LINES = 1 << INDEX_BITS;

   logic [LINES-1:0]  valid;
   logic [TAG_W-1:0]  tags  [LINES];
   logic [WORD_W-1:0] words [LINES];

   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= '0;
      end else if (wr_en) begin
         valid[wr_index] <= 1'b1;
      end
   end

   // Tag and data need no reset: they are meaningless while the valid bit is low.
   always_ff @(posedge clk) begin
      if (wr_en && !rst) begin
         tags[wr_index]  <= wr_tag;
         words[wr_index] <= wr_data;
      end
   end

   assign rd_valid = valid[rd_index];
   assign rd_tag   = tags[rd_index];
   assign rd_data  = words[rd_index];

endmodule

// File: rtl/dcache_ctrl.sv
// MEM-stage data cache controller: direct-mapped, write-through, no-write-allocate.
// Define DCACHE_STATS_EN to add saturating hit_count/miss_count outputs.
module dcache_ctrl
   import dcache_pkg::*;
#(
   parameter int INDEX_BITS = DEF_INDEX_BITS,
   parameter int ADDR_BITS  = DEF_ADDR_BITS
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 mem_read,
   input  logic                 mem_write,
   input  logic [ADDR_BITS-1:0] addr,
   input  logic [WORD_W-1:0]    write_data,
   output logic [WORD_W-1:0]    read_data,
   output logic                 hit,
   output logic                 bus_req,
   output logic                 bus_we,
   output logic [ADDR_BITS-1:0] bus_addr,
   output logic [WORD_W-1:0]    bus_wdata,
   input  logic [WORD_W-1:0]    bus_rdata,
   input  logic                 bus_ready
`ifdef DCACHE_STATS_EN
   ,
   output logic [15:0]          hit_count,
   output logic [15:0]          miss_count
`endif
);

   localparam int TAG_W = tag_width(ADDR_BITS, INDEX_BITS);

   // Handshake: bus_req rises with bus_we/bus_addr/bus_wdata and holds them
   // until the single-cycle bus_ready pulse; bus_ready is ignored unless a
   // request is outstanding.
   state_t                state;
   logic [WORD_W-1:0]     rdata_q;

   logic [INDEX_BITS-1:0] idx;
   logic [TAG_W-1:0]      tag;
   logic                  line_valid;
   logic [TAG_W-1:0]      line_tag;
   logic [WORD_W-1:0]     line_data;
   logic                  tag_match;
   logic                  is_load;
   logic                  load_hit;

   logic                  wr_en;
   logic [INDEX_BITS-1:0] wr_index;
   logic [TAG_W-1:0]      wr_tag;
   logic [WORD_W-1:0]     wr_data;

   assign idx       = addr[INDEX_BITS-1:0];
   assign tag       = addr[ADDR_BITS-1:INDEX_BITS];
   assign tag_match = line_valid && (line_tag == tag);
   assign is_load   = mem_read && !mem_write;
   assign load_hit  = (state == IDLE) && is_load && tag_match;

   dcache_line_store #(
      .INDEX_BITS (INDEX_BITS),
      .TAG_W      (TAG_W)
   ) u_store (
      .clk      (clk),
      .rst      (rst),
      .rd_index (idx),
      .rd_valid (line_valid),
      .rd_tag   (line_tag),
      .rd_data  (line_data),
      .wr_en    (wr_en),
      .wr_index (wr_index),
      .wr_tag   (wr_tag),
      .wr_data  (wr_data)
   );

   always_comb begin
      hit = 1'b0;
      case (state)
         IDLE:             hit = (!mem_read && !mem_write) || load_hit;
         RD_DONE, WR_DONE: hit = 1'b1;
         default:          hit = 1'b0;
      endcase
   end

   assign read_data = load_hit ? line_data : rdata_q;

   // Refill uses the registered request address; a store hit updates in place.
   always_comb begin
      wr_en    = 1'b0;
      wr_index = idx;
      wr_tag   = tag;
      wr_data  = write_data;
      if (state == RD_MISS && bus_ready) begin
         wr_en    = 1'b1;
         wr_index = bus_addr[INDEX_BITS-1:0];
         wr_tag   = bus_addr[ADDR_BITS-1:INDEX_BITS];
         wr_data  = bus_rdata;
      end else if (state == IDLE && mem_write && tag_match) begin
         wr_en = 1'b1;
      end
      if (rst) begin
         wr_en = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         bus_req   <= 1'b0;
         bus_we    <= 1'b0;
         bus_addr  <= '0;
         bus_wdata <= '0;
         rdata_q   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (mem_write) begin
                  state     <= WR_THRU;
                  bus_req   <= 1'b1;
                  bus_we    <= 1'b1;
                  bus_addr  <= addr;
                  bus_wdata <= write_data;
               end else if (mem_read && !tag_match) begin
                  state    <= RD_MISS;
                  bus_req  <= 1'b1;
                  bus_we   <= 1'b0;
                  bus_addr <= addr;
               end
            end
            RD_MISS: begin
               if (bus_ready) begin
                  state   <= RD_DONE;
                  bus_req <= 1'b0;
                  rdata_q <= bus_rdata;
               end
            end
            WR_THRU: begin
               if (bus_ready) begin
                  state   <= WR_DONE;
                  bus_req <= 1'b0;
               end
            end
            RD_DONE, WR_DONE: state <= IDLE;
            default:          state <= IDLE;
         endcase
      end
   end

`ifdef DCACHE_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         if (load_hit && hit_count != 16'hFFFF) begin
            hit_count <= hit_count + 16'd1;
         end
         if (state == IDLE && is_load && !tag_match && miss_count != 16'hFFFF) begin
            miss_count <= miss_count + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: a line-level cache/memory model predicts
// every cycle's outputs, and one negedge process compares them.
module tb_dcache_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_read;
   logic        mem_write;
   logic [15:0] addr;
   logic [15:0] write_data;
   logic [15:0] read_data;
   logic        hit;
   logic        bus_req;
   logic        bus_we;
   logic [15:0] bus_addr;
   logic [15:0] bus_wdata;
   logic [15:0] bus_rdata;
   logic        bus_ready;
`ifdef DCACHE_STATS_EN
   logic [15:0] hit_count;
   logic [15:0] miss_count;
`endif

   always #5 clk = ~clk;

   dcache_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .addr       (addr),
      .write_data (write_data),
      .read_data  (read_data),
      .hit        (hit),
      .bus_req    (bus_req),
      .bus_we     (bus_we),
      .bus_addr   (bus_addr),
      .bus_wdata  (bus_wdata),
      .bus_rdata  (bus_rdata),
      .bus_ready  (bus_ready)
`ifdef DCACHE_STATS_EN
      ,
      .hit_count  (hit_count),
      .miss_count (miss_count)
`endif
   );

   typedef struct {
      logic        hit;
      bit          chk_rd;
      logic [15:0] rd;
      bit          chk_lit;
      logic [15:0] lit;
      logic        breq;
      logic        bwe;
      logic [15:0] baddr;
      logic [15:0] bwdata;
   } exp_t;

   exp_t exp_q[$];
   exp_t cur;

   int vectors    = 0;
   int miscompares = 0;

   // Cache model: what each of the 16 lines holds, plus the backing memory.
   bit          mv[16];
   logic [11:0] mt[16];
   logic [15:0] md[16];
   logic [15:0] bmem[int];
   int          exp_hits   = 0;
   int          exp_misses = 0;

   function automatic logic [15:0] mem_val(input logic [15:0] a);
      if (bmem.exists(int'(a))) return bmem[int'(a)];
      return a ^ 16'h5A5A;
   endfunction

   function automatic exp_t mk(input logic h, input logic breq);
      exp_t e;
      e.hit     = h;
      e.chk_rd  = 1'b0;
      e.rd      = '0;
      e.chk_lit = 1'b0;
      e.lit     = '0;
      e.breq    = breq;
      e.bwe     = 1'b0;
      e.baddr   = '0;
      e.bwdata  = '0;
      return e;
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         cur = exp_q.pop_front();
         chk("hit", {15'd0, hit}, {15'd0, cur.hit});
         chk("bus_req", {15'd0, bus_req}, {15'd0, cur.breq});
         if (cur.chk_rd)  chk("read_data", read_data, cur.rd);
         if (cur.chk_lit) chk("read_data_literal", read_data, cur.lit);
         if (cur.breq) begin
            chk("bus_we", {15'd0, bus_we}, {15'd0, cur.bwe});
            chk("bus_addr", bus_addr, cur.baddr);
            if (cur.bwe) chk("bus_wdata", bus_wdata, cur.bwdata);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_cycle();
      mem_read  = 1'b0;
      mem_write = 1'b0;
      bus_ready = 1'b0;
      exp_q.push_back(mk(1'b1, 1'b0));
      tick();
   endtask

   // lit < 0 means no hand-computed literal for the returned data.
   task automatic do_read(input logic [15:0] a, input int lat, input int lit);
      exp_t e;
      int   i;
      logic [15:0] v;
      i = int'(a[3:0]);
      mem_read  = 1'b1;
      mem_write = 1'b0;
      addr      = a;
      bus_ready = 1'b0;
      if (mv[i] && mt[i] == a[15:4]) begin
         e = mk(1'b1, 1'b0);
         e.chk_rd = 1'b1;
         e.rd     = md[i];
         if (lit >= 0) begin e.chk_lit = 1'b1; e.lit = lit[15:0]; end
         exp_q.push_back(e);
         exp_hits++;
         tick();
      end else begin
         v = mem_val(a);
         exp_misses++;
         exp_q.push_back(mk(1'b0, 1'b0));
         tick();
         for (int c = 1; c <= lat; c++) begin
            bus_ready = (c == lat);
            bus_rdata = (c == lat) ? v : 16'h0BAD;
            e = mk(1'b0, 1'b1);
            e.baddr = a;
            exp_q.push_back(e);
            tick();
         end
         bus_ready = 1'b0;
         bus_rdata = 16'h0BAD;
         e = mk(1'b1, 1'b0);
         e.chk_rd = 1'b1;
         e.rd     = v;
         if (lit >= 0) begin e.chk_lit = 1'b1; e.lit = lit[15:0]; end
         exp_q.push_back(e);
         mv[i] = 1'b1;
         mt[i] = a[15:4];
         md[i] = v;
         tick();
      end
      mem_read = 1'b0;
   endtask

   task automatic do_write(input logic [15:0] a, input logic [15:0] d, input int lat,
                           input logic also_read);
      exp_t e;
      int   i;
      i = int'(a[3:0]);
      mem_read   = also_read;
      mem_write  = 1'b1;
      addr       = a;
      write_data = d;
      bus_ready  = 1'b0;
      exp_q.push_back(mk(1'b0, 1'b0));
      tick();
      for (int c = 1; c <= lat; c++) begin
         bus_ready = (c == lat);
         e = mk(1'b0, 1'b1);
         e.bwe    = 1'b1;
         e.baddr  = a;
         e.bwdata = d;
         exp_q.push_back(e);
         tick();
      end
      bus_ready = 1'b0;
      exp_q.push_back(mk(1'b1, 1'b0));
      bmem[int'(a)] = d;
      if (mv[i] && mt[i] == a[15:4]) md[i] = d;
      tick();
      mem_read  = 1'b0;
      mem_write = 1'b0;
   endtask

   task automatic reset_model();
      for (int k = 0; k < 16; k++) mv[k] = 1'b0;
      exp_hits   = 0;
      exp_misses = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      rst        = 1'b1;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      addr       = '0;
      write_data = '0;
      bus_rdata  = 16'h0BAD;
      bus_ready  = 1'b0;
      reset_model();
      bmem[16'h0013] = 16'hBEEF;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset state: idle, no request, load data register cleared.
      e = mk(1'b1, 1'b0);
      e.chk_lit = 1'b1;
      e.lit     = 16'h0000;
      exp_q.push_back(e);
      tick();

      do_read(16'h0013, 3, 16'hBEEF);
      do_read(16'h0013, 1, 16'hBEEF);
      do_read(16'h0023, 2, 16'h5A79);
      do_read(16'h0013, 4, 16'hBEEF);
      idle_cycle();

      do_write(16'h0013, 16'h1234, 3, 1'b0);
      do_read(16'h0013, 1, 16'h1234);
      do_write(16'h0050, 16'hCAFE, 2, 1'b0);
      do_read(16'h0050, 2, 16'hCAFE);
      do_read(16'h0050, 1, 16'hCAFE);
      do_write(16'h0050, 16'h7777, 1, 1'b1);
      do_read(16'h0050, 1, 16'h7777);
      do_read(16'hFFFF, 2, 16'hA5A5);
      do_read(16'hFFFF, 1, 16'hA5A5);
      idle_cycle();

      // Reset while a refill is outstanding, then a stale bus_ready pulse.
      mem_read = 1'b1;
      addr     = 16'h0033;
      exp_q.push_back(mk(1'b0, 1'b0));
      tick();
      e = mk(1'b0, 1'b1);
      e.baddr = 16'h0033;
      exp_q.push_back(e);
      tick();
      rst = 1'b1;
      tick();
      rst       = 1'b0;
      reset_model();
      mem_read  = 1'b0;
      bus_ready = 1'b1;
      bus_rdata = 16'hDEAD;
      exp_q.push_back(mk(1'b1, 1'b0));
      tick();
      bus_ready = 1'b0;
      bus_rdata = 16'h0BAD;
      exp_q.push_back(mk(1'b1, 1'b0));
      tick();

      do_read(16'h0033, 2, -1);
      do_read(16'h0050, 1, 16'h7777);
      do_read(16'hFFFF, 3, 16'hA5A5);
      do_read(16'h0050, 1, 16'h7777);
      do_read(16'h0050, 1, 16'h7777);
      idle_cycle();

      @(negedge clk);
`ifdef DCACHE_STATS_EN
      chk("hit_count", hit_count, exp_hits[15:0]);
      chk("miss_count", miss_count, exp_misses[15:0]);
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
